aes_round_controller: RTL
=========================

Name: aes_round_controller

Overview:
- Sequences the AES-128 encryption round datapath: the SubBytes, ShiftRows, MixColumns and AddRoundKey stage registers, plus the input load.
- Accepts one 132-bit block per transaction (4-bit header + 128-bit state) over a valid/ready handshake.
- Fetches round keys from the key-expansion store over a req/valid handshake and presents the finished block with backpressure.
- Sits between the packet front-end and the round-stage datapath. It owns no data bits, only control, round count and header.

Parameters:
NUM_ROUNDS, 10, total AES rounds; round NUM_ROUNDS omits MixColumns
HDR_W, 4, header width carried alongside each block

Ports:
clk  in  1  clock
n_rst  in  1  reset, synchronous, active-low
in_valid  in  1  upstream block available on datapath input
in_ready  out  1  controller idle, can accept a block
header_in  in  HDR_W  header of offered block (data_in[131:128])
load_en  out  1  datapath captures data_in into state register
sub_en  out  1  SubBytes stage enable
shift_en  out  1  ShiftRows stage enable
mix_en  out  1  MixColumns stage enable
ark_en  out  1  AddRoundKey stage enable
round_num  out  4  current round, 0..NUM_ROUNDS
key_req  out  1  round key requested
key_idx  out  4  index of requested round key (= round_num)
key_valid  in  1  requested round key present on key bus this cycle
out_valid  out  1  finished block valid on datapath output
out_ready  in  1  downstream accepts finished block
header_out  out  HDR_W  header of block in flight/finished
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock domain. State, round counter and header are registered. While n_rst=0 at a rising edge: state←IDLE, round_num←0, header_out←0.
- Reset values after that edge: out_valid=0, busy=0, key_req=0, all stage enables 0, in_ready=1.
- A reset that lands mid-block abandons the block. No out_valid is produced for it.
- States: IDLE, INIT_ARK, SUB, SHIFT, MIX, ARK, DONE.
- IDLE:
  - in_ready=1.
  - load_en = in_valid & in_ready (combinational).
  - On the accept edge: latch header_in, round_num←0, go to INIT_ARK.
- INIT_ARK:
  - key_req=1, key_idx=0.
  - ark_en = key_valid.
  - Stays until key_valid=1. On that edge: round_num←1, go to SUB.
- SUB: sub_en=1 for exactly one cycle, then SHIFT.
- SHIFT: shift_en=1 for one cycle. Next state is MIX if round_num<NUM_ROUNDS, else ARK (final round skips MixColumns).
- MIX: mix_en=1 for one cycle, then ARK.
- ARK:
  - key_req=1, key_idx=round_num.
  - ark_en = key_valid.
  - Stalls while key_valid=0, with no other enable asserted.
  - On the key_valid edge: if round_num==NUM_ROUNDS go to DONE; else round_num+1 and go to SUB.
- DONE:
  - out_valid=1; header_out and round_num (=NUM_ROUNDS) held.
  - Stays until out_ready=1. On that edge go to IDLE and round_num←0.
  - in_ready stays 0 in DONE, so there is no same-cycle accept.
- Mutual exclusion: at most one of load_en/sub_en/shift_en/mix_en/ark_en is high in any cycle.
- Latency with key_valid tied 1 and NUM_ROUNDS=10: 1 + 9×4 + 3 = 40 cycles. out_valid rises at the 40th rising edge after the accept edge.
- Each key stall adds exactly one cycle per low key_valid cycle.
- key_valid is ignored outside INIT_ARK/ARK.
- in_valid is ignored outside IDLE.
- header_out changes only on accept or reset.
- Round counter is 4 bits and saturates at NUM_ROUNDS. It never wraps.

Decomposition:
- Shared package aes_pkg holds:
  - state enum aes_ctrl_state_t
  - constants AES_NUM_ROUNDS=10, AES_BLOCK_W=128, AES_HDR_W=4, AES_DATA_W=132
  - the datapath reuses these widths.
- One sub-module, aes_round_counter:
  - 4-bit register with clr, inc and last = (count==NUM_ROUNDS).
  - Instantiated once.
- FSM next-state/output decode stays in aes_round_controller.

Test Plan:
- Reset then idle: n_rst=0 for 2 edges → in_ready=1, busy=0, out_valid=0, round_num=0, header_out=0, all enables 0.
- Single block, key_valid=1, header_in=4'h7 → load_en one cycle. Enable trace is ark, then (sub,shift,mix,ark)×9, then sub,shift,ark. mix_en pulses exactly 9 times. out_valid=1 at edge 40 with header_out=7 and round_num=10.
- Key stall: key_valid=0 for 3 cycles during round-5 ARK → key_idx=5 held, no enables asserted, out_valid at edge 43.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid and header_out stable, in_ready=0. First cycle after out_ready=1 gives in_ready=1.
- Back-to-back: in_valid held high with headers 3 then 9 → second load_en occurs the cycle after the first block's out_ready handshake, and header_out=9 on the second out_valid.
- Mid-operation reset: n_rst=0 during round 6 SUB → state IDLE after that edge, no out_valid, next block completes in 40 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and widths used by the round controller and the round datapath.
package aes_pkg;

  localparam int unsigned AES_NUM_ROUNDS = 10;
  localparam int unsigned AES_BLOCK_W    = 128;
  localparam int unsigned AES_HDR_W      = 4;
  localparam int unsigned AES_DATA_W     = AES_BLOCK_W + AES_HDR_W;
  localparam int unsigned AES_ROUND_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT_ARK = 3'd1,
    ST_SUB      = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_MIX      = 3'd4,
    ST_ARK      = 3'd5,
    ST_DONE     = 3'd6
  } aes_ctrl_state_t;

endpackage

// File: rtl/aes_round_counter.sv
// Saturating AES round counter: clear, increment, and a flag for the final round.
module aes_round_counter
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clr_i,
  input  logic                   inc_i,
  output logic [AES_ROUND_W-1:0] count_o,
  output logic                   last_o
);

  logic [AES_ROUND_W-1:0] count_q, count_d;

  assign last_o  = (count_q == AES_ROUND_W'(NUM_ROUNDS));
  assign count_o = count_q;

  // Clear wins over increment; increment stops at the final round.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !last_o) begin
      count_d = count_q + AES_ROUND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/aes_round_controller.sv
// AES-128 round sequencer: drives stage enables, round-key requests and the
// block handshakes; holds only control state, the round count and the header.
module aes_round_controller
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int unsigned HDR_W      = AES_HDR_W
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [HDR_W-1:0]       header_in,
  output logic                   load_en,
  output logic                   sub_en,
  output logic                   shift_en,
  output logic                   mix_en,
  output logic                   ark_en,
  output logic [AES_ROUND_W-1:0] round_num,
  output logic                   key_req,
  output logic [AES_ROUND_W-1:0] key_idx,
  input  logic                   key_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [HDR_W-1:0]       header_out,
  output logic                   busy
);

  aes_ctrl_state_t  state_q, state_d;
  logic [HDR_W-1:0] hdr_q;
  logic             accept;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_last;

  aes_round_counter #(
    .NUM_ROUNDS(NUM_ROUNDS)
  ) u_round_counter (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .count_o(round_num),
    .last_o (cnt_last)
  );

  assign accept = in_valid & in_ready;

  // Next-state and round-counter control.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_INIT_ARK;
          cnt_clr = 1'b1;
        end
      end
      ST_INIT_ARK: begin
        if (key_valid) begin
          state_d = ST_SUB;
          cnt_inc = 1'b1;
        end
      end
      ST_SUB:   state_d = ST_SHIFT;
      ST_SHIFT: state_d = cnt_last ? ST_ARK : ST_MIX;
      ST_MIX:   state_d = ST_ARK;
      ST_ARK: begin
        if (key_valid) begin
          if (cnt_last) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SUB;
            cnt_inc = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hdr_q <= header_in;
      end
    end
  end

  // Enables decode from the registered state; load and key-gated ARK also follow their inputs.
  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign load_en    = accept;
  assign sub_en     = (state_q == ST_SUB);
  assign shift_en   = (state_q == ST_SHIFT);
  assign mix_en     = (state_q == ST_MIX);
  assign key_req    = (state_q == ST_INIT_ARK) || (state_q == ST_ARK);
  assign ark_en     = key_req & key_valid;
  assign key_idx    = round_num;
  assign out_valid  = (state_q == ST_DONE);
  assign header_out = hdr_q;

endmodule
